// File: rtl/spell_mem_pkg.sv
// Shared definitions for the spell memory requester and spell_mem_dff:
// FSM state encoding, default memory sizes and the address range check.
package spell_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int DEFAULT_CODE_SIZE = 32;
  localparam int DEFAULT_DATA_SIZE = 8;

  function automatic logic addr_out_of_range(input logic       type_data,
                                             input logic [7:0] addr,
                                             input int         code_size,
                                             input int         data_size);
    if (type_data) begin
      return int'(addr) >= data_size;
    end
    return int'(addr) >= code_size;
  endfunction

endpackage

// File: rtl/spell_mem_requester.sv
// Single-outstanding memory requester: IDLE -> ISSUE -> RELEASE handshake.
// Optional ISSUE timeout is compiled in with `define SPELL_MEM_TIMEOUT_EN.
module spell_mem_requester
  import spell_mem_pkg::*;
#(
  parameter int CODE_SIZE      = DEFAULT_CODE_SIZE,
  parameter int DATA_SIZE      = DEFAULT_DATA_SIZE,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_type_data,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic       resp_error,
  output logic       select,
  output logic [7:0] addr,
  output logic [7:0] data_in,
  output logic       memory_type_data,
  output logic       write,
  input  logic [7:0] data_out,
  input  logic       data_ready
);

  state_t     state_q, state_d;
  logic       select_q, select_d;
  logic       write_q, write_d;
  logic       type_data_q, type_data_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_in_q, data_in_d;
  logic       resp_valid_q, resp_valid_d;
  logic       resp_error_q, resp_error_d;
  logic [7:0] resp_rdata_q, resp_rdata_d;

`ifdef SPELL_MEM_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timeout_cnt_q, timeout_cnt_d;
`else
  // Without the timeout TIMEOUT_CYCLES has no effect; this keeps it referenced.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_ignored
  end
`endif

  always_comb begin
    state_d      = state_q;
    select_d     = select_q;
    write_d      = write_q;
    type_data_d  = type_data_q;
    addr_d       = addr_q;
    data_in_d    = data_in_q;
    resp_valid_d = 1'b0;
    resp_error_d = resp_error_q;
    resp_rdata_d = resp_rdata_q;
`ifdef SPELL_MEM_TIMEOUT_EN
    timeout_cnt_d = timeout_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d       = req_addr;
          data_in_d    = req_wdata;
          type_data_d  = req_type_data;
          write_d      = req_write;
          resp_rdata_d = 8'd0;
          if (addr_out_of_range(req_type_data, req_addr, CODE_SIZE, DATA_SIZE)) begin
            // Range errors never touch the memory: answer straight from RELEASE.
            state_d      = RELEASE;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else begin
            state_d      = ISSUE;
            select_d     = 1'b1;
            resp_error_d = 1'b0;
`ifdef SPELL_MEM_TIMEOUT_EN
            timeout_cnt_d = '0;
`endif
          end
        end
      end
      ISSUE: begin
        if (data_ready) begin
          state_d      = RELEASE;
          select_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_error_d = 1'b0;
          resp_rdata_d = write_q ? 8'd0 : data_out;
`ifdef SPELL_MEM_TIMEOUT_EN
        end else if (timeout_cnt_q == TIMEOUT_LAST) begin
          state_d      = RELEASE;
          select_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_error_d = 1'b1;
          resp_rdata_d = 8'd0;
        end else begin
          timeout_cnt_d = timeout_cnt_q + TW'(1);
`endif
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        select_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      select_q     <= 1'b0;
      write_q      <= 1'b0;
      type_data_q  <= 1'b0;
      addr_q       <= 8'd0;
      data_in_q    <= 8'd0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= 8'd0;
`ifdef SPELL_MEM_TIMEOUT_EN
      timeout_cnt_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      select_q     <= select_d;
      write_q      <= write_d;
      type_data_q  <= type_data_d;
      addr_q       <= addr_d;
      data_in_q    <= data_in_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
`ifdef SPELL_MEM_TIMEOUT_EN
      timeout_cnt_q <= timeout_cnt_d;
`endif
    end
  end

  assign req_ready        = (state_q == IDLE);
  assign resp_valid       = resp_valid_q;
  assign resp_error       = resp_error_q;
  assign resp_rdata       = resp_rdata_q;
  assign select           = select_q;
  assign addr             = addr_q;
  assign data_in          = data_in_q;
  assign memory_type_data = type_data_q;
  assign write            = write_q;

endmodule

// File: tb/tb_spell_mem_requester.sv
// Scoreboard bench for spell_mem_requester with a registered memory model
// that supports extra wait states and a never-ready mode.
module tb_spell_mem_requester;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_write, req_type_data;
  logic [7:0] req_addr, req_wdata;
  logic       resp_valid, resp_error;
  logic [7:0] resp_rdata;
  logic       select, memory_type_data, write;
  logic [7:0] addr, data_in, data_out;
  logic       data_ready;

  spell_mem_requester #(
    .CODE_SIZE(32),
    .DATA_SIZE(8),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_type_data(req_type_data), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .select(select), .addr(addr), .data_in(data_in),
    .memory_type_data(memory_type_data), .write(write),
    .data_out(data_out), .data_ready(data_ready)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory model: registered response, mem_delay extra wait cycles, mem_hang never answers.
  logic [7:0] code_mem [32];
  logic [7:0] data_mem [8];
  int  mem_delay = 0;
  bit  mem_hang  = 1'b0;
  int  wait_cnt;
  bit  served;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      data_ready <= 1'b0;
      data_out   <= 8'd0;
      wait_cnt   <= 0;
      served     <= 1'b0;
    end else if (!select) begin
      data_ready <= 1'b0;
      wait_cnt   <= 0;
      served     <= 1'b0;
    end else if (served) begin
      data_ready <= 1'b0;
    end else if (!mem_hang && wait_cnt == mem_delay) begin
      data_ready <= 1'b1;
      served     <= 1'b1;
      if (write) begin
        if (memory_type_data) data_mem[addr[2:0]] <= data_in;
        else                  code_mem[addr[4:0]] <= data_in;
      end else begin
        data_out <= memory_type_data ? data_mem[addr[2:0]] : code_mem[addr[4:0]];
      end
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  typedef struct {
    string      tag;
    logic [7:0] rdata;
    logic       err;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb_q[$];
  int   last_resp_cyc = 0;
  bit   sel_seen = 1'b0;

  always @(negedge clock) begin
    if (select) sel_seen = 1'b1;
    if (resp_valid) begin
      last_resp_cyc = cyc;
      if (sb_q.size() == 0) begin
        check_val("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val({e.tag, "_rdata"}, {24'd0, resp_rdata}, {24'd0, e.rdata});
        check_val({e.tag, "_error"}, {31'd0, resp_error}, {31'd0, e.err});
        check_val({e.tag, "_latency"}, cyc - e.acc, e.lat);
        check_val({e.tag, "_ready_in_release"}, {31'd0, req_ready}, 32'd0);
        $display("resp %s rdata=%02h err=%0b cycle=%0d", e.tag, resp_rdata, resp_error, cyc);
      end
    end
  end

  task automatic do_req(input logic w, input logic t, input logic [7:0] a, input logic [7:0] wd,
                        input logic [7:0] rd, input logic err, input int lat, input string tag);
    int n;
    n = 0;
    @(negedge clock);
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      check_val({tag, "_accept_timeout"}, 32'd0, 32'd1);
      return;
    end
    req_write     = w;
    req_type_data = t;
    req_addr      = a;
    req_wdata     = wd;
    req_valid     = 1'b1;
    sb_q.push_back('{tag: tag, rdata: rd, err: err, lat: lat, acc: cyc});
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (sb_q.size() != 0) begin
      check_val({tag, "_resp_timeout"}, 32'd0, 32'd1);
      sb_q.delete();
      return;
    end
    while (cyc < last_resp_cyc + 1) @(negedge clock);
    check_val({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_type_data = 1'b0;
    req_addr = 8'd0; req_wdata = 8'd0;
    for (int i = 0; i < 32; i++) code_mem[i] = 8'd0;
    for (int i = 0; i < 8; i++)  data_mem[i] = 8'd0;
    code_mem[5]  = 8'hA5;
    code_mem[31] = 8'h5A;

    repeat (2) @(negedge clock);
    check_val("rst_select", {31'd0, select}, 32'd0);
    check_val("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_val("rst_addr", {24'd0, addr}, 32'd0);
    check_val("rst_write", {31'd0, write}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check_val("rst_ready", {31'd0, req_ready}, 32'd1);

    do_req(1'b0, 1'b0, 8'd5, 8'd0, 8'hA5, 1'b0, 3, "read_code5");

    do_req(1'b1, 1'b1, 8'd3, 8'h3C, 8'h00, 1'b0, 3, "write_data3");
    check_val("hold_addr", {24'd0, addr}, 32'd3);
    check_val("hold_data_in", {24'd0, data_in}, 32'h3C);
    check_val("hold_write", {31'd0, write}, 32'd1);
    check_val("hold_type", {31'd0, memory_type_data}, 32'd1);
    check_val("mem_data3", {24'd0, data_mem[3]}, 32'h3C);
    do_req(1'b0, 1'b1, 8'd3, 8'd0, 8'h3C, 1'b0, 3, "read_data3");

    sel_seen = 1'b0;
    do_req(1'b0, 1'b1, 8'd8, 8'd0, 8'h00, 1'b1, 1, "range_data8");
    do_req(1'b0, 1'b0, 8'd32, 8'd0, 8'h00, 1'b1, 1, "range_code32");
    check_val("range_no_select", {31'd0, sel_seen}, 32'd0);

    mem_delay = 3;
    do_req(1'b0, 1'b0, 8'd31, 8'd0, 8'h5A, 1'b0, 6, "delay_code31");
    mem_delay = 0;

`ifdef SPELL_MEM_TIMEOUT_EN
    mem_hang = 1'b1;
    do_req(1'b0, 1'b0, 8'd2, 8'd0, 8'h00, 1'b1, 5, "timeout_code2");
    mem_hang = 1'b0;
`endif

    // Reset while ISSUE waits on a memory that never answers.
    mem_hang = 1'b1;
    @(negedge clock);
    req_write = 1'b0; req_type_data = 1'b0; req_addr = 8'd1; req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    check_val("midissue_select", {31'd0, select}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_val("midissue_select_cleared", {31'd0, select}, 32'd0);
    check_val("midissue_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    mem_hang = 1'b0;
    @(negedge clock);
    check_val("midissue_ready_after", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clock);
    $display("reset mid-issue done cycle=%0d", cyc);

    do_req(1'b0, 1'b0, 8'd5, 8'd0, 8'hA5, 1'b0, 3, "recover_code5");

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spell_mem_requester.md
SPELL_MEM_REQUESTER -- requirements
Module: spell_mem_requester

Interface
REQ-001 SHALL have parameter CODE_SIZE, default 32, number of code bytes the memory implements.
REQ-002 SHALL have parameter DATA_SIZE, default 8, number of data bytes the memory implements.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum cycles in ISSUE waiting for data_ready (used only with timeout compiled in).
REQ-004 SHALL have ports:
- clock  in  1  single clock, all flops on rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  core request present.
- req_ready  out  1  requester can accept a request.
- req_write  in  1  1=write, 0=read.
- req_type_data  in  1  1=data memory, 0=code memory.
- req_addr  in  8  byte address.
- req_wdata  in  8  write data.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  8  read data; 0 for writes and errors.
- resp_error  out  1  range or timeout error, qualified by resp_valid.
- select  out  1  memory select.
- addr  out  8  memory address.
- data_in  out  8  memory write data.
- memory_type_data  out  1  memory space select.
- write  out  1  memory write strobe.
- data_out  in  8  memory read data.
- data_ready  in  1  memory completion.

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, RELEASE, with exactly one request outstanding.
REQ-006 SHALL assert req_ready only in IDLE; a request is accepted when req_valid && req_ready on a rising edge.
REQ-007 SHALL, on acceptance, register addr, data_in, memory_type_data and write from the req_* inputs; hold them stable until the next acceptance.
REQ-008 SHALL check the range on acceptance: out of range is (req_type_data && req_addr >= DATA_SIZE) || (!req_type_data && req_addr >= CODE_SIZE).
REQ-009 SHALL, for an out-of-range request, not assert select; go to RELEASE; pulse resp_valid with resp_error=1 and resp_rdata=0 in the next cycle.
REQ-010 SHALL, for an in-range request, enter ISSUE with select=1 in the cycle after acceptance.
REQ-011 SHALL, in ISSUE, sample data_ready each edge; when it is 1, capture data_out (reads) into resp_rdata (0 for writes) and go to RELEASE.
REQ-012 SHALL, in RELEASE, drive select=0 for exactly one cycle, pulse resp_valid=1 (resp_error=0 on success), ignore data_ready, then return to IDLE.
REQ-013 SHALL, with a zero-wait memory, give: accept at cycle 0, select high in cycles 1-2, resp_valid in cycle 3, req_ready in cycle 4 (4-cycle throughput).
REQ-014 SHALL give resp_valid no backpressure; it is high for exactly one cycle per accepted request.
REQ-015 SHALL ignore data_ready in IDLE.

Reset
REQ-016 SHALL, on reset assertion and independent of clock, force state=IDLE and clear select, write, memory_type_data, addr, data_in, resp_valid, resp_error, resp_rdata and the timeout counter.
REQ-017 SHALL abandon any in-flight transaction on reset mid-ISSUE, with no resp_valid; req_ready=1 on the first edge after reset deasserts.

Configuration
REQ-018 SHALL, when SPELL_MEM_TIMEOUT_EN is defined, count cycles in ISSUE (the counter clears on entry).
REQ-019 SHALL, with SPELL_MEM_TIMEOUT_EN defined, go to RELEASE after TIMEOUT_CYCLES cycles in ISSUE without data_ready; the response then has resp_error=1 and resp_rdata=0.
REQ-020 SHALL, when SPELL_MEM_TIMEOUT_EN is not defined, have no counter; ISSUE waits indefinitely.

Structure
REQ-021 SHALL take from shared package spell_mem_pkg: state encoding (IDLE=2'd0, ISSUE=2'd1, RELEASE=2'd2) and the default CODE_SIZE/DATA_SIZE constants, also shared with spell_mem_dff.
REQ-022 SHALL be a single module with no sub-module; the timeout counter is inline, under the macro.

Verification
REQ-023 Bench SHALL cover:
- Zero-wait read: preload code[5]=8'hA5 -> read type=0 addr=5 -> resp_valid cycle 3, rdata=8'hA5, error=0.
- Write then read: write data addr=3 wdata=8'h3C -> resp error=0 rdata=0, then read data addr=3 -> 8'h3C.
- Range: read data addr=8 -> select never high, resp_valid one cycle after accept, error=1, rdata=0.
- Delayed memory (DFF_DELAY, 3 wait cycles): read code addr=31 -> resp_valid 3 cycles later than zero-wait, correct data.
- Timeout (SPELL_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, data_ready held 0) -> error=1 after 4 ISSUE cycles; FSM back in IDLE.
- Async reset mid-ISSUE -> select=0 immediately, no resp_valid, req_ready=1 after release.
